// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranging controller: triggers front/rear sensors in turn,
// times the echo pulse, converts it to millimetres and publishes the nearer distance.
module sonar_scheduler #(
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned CYCLES_PER_MM = 290,
  parameter int unsigned WAIT_CYCLES   = 1000000,
  parameter int unsigned GUARD_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_en,
  input  logic [1:0]  echo,
  output logic [1:0]  trig,
  output logic [11:0] dst_front,
  output logic [11:0] dst_rear,
  output logic [11:0] binary_dst,
  output logic        dst_valid,
  output logic [1:0]  timeout,
  output logic        sel
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRIG  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MEAS  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam logic [11:0] DST_MAX    = 12'd4095;
  localparam logic [11:0] DST_PRESAT = 12'd4094;
  localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYCLES - 1);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] SUB_LAST   = 32'(CYCLES_PER_MM - 1);
  // The rise-detect cycle is already a high cycle, so counting starts one step in.
  localparam logic [31:0] SUB_INIT   = (CYCLES_PER_MM == 1) ? 32'd0 : 32'd1;
  localparam logic [11:0] MM_INIT    = (CYCLES_PER_MM == 1) ? 12'd1 : 12'd0;

  function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
    min12 = (a < b) ? a : b;
  endfunction

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] sub_q;
  logic [31:0] sub_d;
  logic [11:0] mm_q;
  logic [11:0] mm_d;
  logic [1:0]  trig_q;
  logic        sel_q;
  logic [11:0] dst_front_q;
  logic [11:0] dst_rear_q;
  logic [1:0]  timeout_q;
  logic        publish_q;
  logic [11:0] binary_dst_q;
  logic        dst_valid_q;
  logic [1:0]  echo_s1_q;
  logic [1:0]  echo_s2_q;
  logic [1:0]  echo_s3_q;

  logic        echo_cur_s;
  logic        echo_prev_s;
  logic        rise_s;
  logic        fall_s;
  logic        sub_wrap_s;
  logic        mm_sat_s;
  logic        finish_s;
  logic [11:0] result_s;
  logic        to_s;

  // Two-flop synchronizer plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1_q <= 2'b00;
      echo_s2_q <= 2'b00;
      echo_s3_q <= 2'b00;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  // Edge detect on the sensor currently owning the datapath.
  always_comb begin
    echo_cur_s  = echo_s2_q[sel_q];
    echo_prev_s = echo_s3_q[sel_q];
    rise_s      = echo_cur_s & ~echo_prev_s;
    fall_s      = ~echo_cur_s & echo_prev_s;
  end

  // Millimetre counter step: sub-counter wraps every CYCLES_PER_MM high cycles.
  always_comb begin
    sub_wrap_s = (sub_q == SUB_LAST);
    if (sub_wrap_s) begin
      sub_d = 32'd0;
      mm_d  = mm_q + 12'd1;
    end else begin
      sub_d = sub_q + 32'd1;
      mm_d  = mm_q;
    end
    mm_sat_s = sub_wrap_s && (mm_q == DST_PRESAT);
  end

  // Shot completion: timeout, normal echo fall, or saturation while echo is high.
  always_comb begin
    finish_s = 1'b0;
    result_s = mm_q;
    to_s     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!rise_s && (cnt_q == WAIT_LAST)) begin
          finish_s = 1'b1;
          result_s = DST_MAX;
          to_s     = 1'b1;
        end else begin
          finish_s = 1'b0;
          result_s = mm_q;
          to_s     = 1'b0;
        end
      end
      ST_MEAS: begin
        if (fall_s) begin
          finish_s = 1'b1;
          result_s = mm_q;
          to_s     = 1'b0;
        end else if (mm_sat_s) begin
          finish_s = 1'b1;
          result_s = DST_MAX;
          to_s     = 1'b1;
        end else begin
          finish_s = 1'b0;
          result_s = mm_q;
          to_s     = 1'b0;
        end
      end
      default: begin
        finish_s = 1'b0;
        result_s = mm_q;
        to_s     = 1'b0;
      end
    endcase
  end

  // Measurement sequencer with registered trigger, selection and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      sub_q       <= 32'd0;
      mm_q        <= 12'd0;
      trig_q      <= 2'b00;
      sel_q       <= 1'b0;
      dst_front_q <= DST_MAX;
      dst_rear_q  <= DST_MAX;
      timeout_q   <= 2'b00;
      publish_q   <= 1'b0;
    end else begin
      publish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (meas_en) begin
            trig_q  <= sel_q ? 2'b10 : 2'b01;
            cnt_q   <= 32'd0;
            state_q <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            trig_q  <= 2'b00;
            cnt_q   <= 32'd0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_WAIT: begin
          if (rise_s) begin
            sub_q   <= SUB_INIT;
            mm_q    <= MM_INIT;
            state_q <= ST_MEAS;
          end else if (finish_s) begin
            if (sel_q) begin
              dst_rear_q <= result_s;
            end else begin
              dst_front_q <= result_s;
            end
            timeout_q[sel_q] <= to_s;
            publish_q        <= 1'b1;
            cnt_q            <= 32'd0;
            state_q          <= ST_GUARD;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_MEAS: begin
          if (finish_s) begin
            if (sel_q) begin
              dst_rear_q <= result_s;
            end else begin
              dst_front_q <= result_s;
            end
            timeout_q[sel_q] <= to_s;
            publish_q        <= 1'b1;
            cnt_q            <= 32'd0;
            state_q          <= ST_GUARD;
          end else begin
            sub_q <= sub_d;
            mm_q  <= mm_d;
          end
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            sel_q <= ~sel_q;
            cnt_q <= 32'd0;
            if (meas_en) begin
              trig_q  <= sel_q ? 2'b01 : 2'b10;
              state_q <= ST_TRIG;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          trig_q  <= 2'b00;
          cnt_q   <= 32'd0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Nearest-distance publication, one cycle after the per-sensor result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_dst_q <= DST_MAX;
      dst_valid_q  <= 1'b0;
    end else begin
      dst_valid_q <= publish_q;
      if (publish_q) begin
        binary_dst_q <= min12(dst_front_q, dst_rear_q);
      end
    end
  end

  assign trig       = trig_q;
  assign sel        = sel_q;
  assign dst_front  = dst_front_q;
  assign dst_rear   = dst_rear_q;
  assign timeout    = timeout_q;
  assign binary_dst = binary_dst_q;
  assign dst_valid  = dst_valid_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Scoreboard bench for sonar_scheduler: directed shots push expected results,
// a monitor compares them on every dst_valid pulse.
module tb_sonar_scheduler;

  localparam int TRIG  = 10;
  localparam int CPM   = 4;
  localparam int WAITC = 100;
  localparam int GUARD = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_en;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic [11:0] dst_front;
  logic [11:0] dst_rear;
  logic [11:0] binary_dst;
  logic        dst_valid;
  logic [1:0]  timeout;
  logic        sel;

  typedef struct packed {
    logic [11:0] bin;
    logic [11:0] fr;
    logic [11:0] rr;
    logic [1:0]  to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  sonar_scheduler #(
    .TRIG_CYCLES(TRIG), .CYCLES_PER_MM(CPM), .WAIT_CYCLES(WAITC), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .meas_en(meas_en), .echo(echo), .trig(trig),
    .dst_front(dst_front), .dst_rear(dst_rear), .binary_dst(binary_dst),
    .dst_valid(dst_valid), .timeout(timeout), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every published result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && dst_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got pulse, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("binary_dst", 32'(binary_dst), 32'(mon_e.bin));
        check("dst_front",  32'(dst_front),  32'(mon_e.fr));
        check("dst_rear",   32'(dst_rear),   32'(mon_e.rr));
        check("timeout",    32'(timeout),    32'(mon_e.to));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One shot: wait for trigger, check it, drive echo, push expected result.
  task automatic do_shot(input int sensor, input int width, input int drop_at,
                         input bit sat, input exp_t e, output int wait_n);
    int n;
    int hi;
    bit onehot_ok;
    bit seen;
    n = 0;
    while (trig == 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    check("trig_start", 32'(trig), 32'(1 << sensor));
    check("sel", 32'(sel), 32'(sensor));
    hi = 0;
    onehot_ok = 1'b1;
    while (trig != 2'b00 && hi < 50) begin
      if (trig != 2'(1 << sensor)) onehot_ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    check("trig_width", 32'(hi), 32'(TRIG));
    check("trig_onehot", 32'(onehot_ok), 32'd1);
    exp_q.push_back(e);
    if (width == 0) begin
      n = 0;
      while (!dst_valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", 32'(n), 32'(WAITC + 1));
    end else begin
      repeat (5) @(negedge clk);
      echo[sensor] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < width; i++) begin
        @(negedge clk);
        if (i == drop_at) meas_en = 1'b0;
        if (sat && dst_valid) begin
          seen = 1'b1;
          break;
        end
      end
      echo[sensor] = 1'b0;
      if (sat) begin
        check("sat_before_fall", 32'(seen), 32'd1);
      end else begin
        n = 0;
        while (!dst_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("fall_latency", 32'(n), 32'd4);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int w;
    int acc_trig;
    int acc_valid;
    rst     = 1'b1;
    meas_en = 1'b0;
    echo    = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_trig",   32'(trig), 32'd0);
    check("rst_sel",    32'(sel), 32'd0);
    check("rst_to",     32'(timeout), 32'd0);
    check("rst_front",  32'(dst_front), 32'd4095);
    check("rst_rear",   32'(dst_rear), 32'd4095);
    check("rst_binary", 32'(binary_dst), 32'd4095);
    acc_trig = 0;
    acc_valid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trig != 2'b00) acc_trig++;
      if (dst_valid) acc_valid++;
    end
    check("idle_trig", 32'(acc_trig), 32'd0);
    check("idle_valid", 32'(acc_valid), 32'd0);

    meas_en = 1'b1;
    do_shot(0, 600, -1, 1'b0, exp_t'{12'd150, 12'd150, 12'd4095, 2'b00}, w);
    check("first_trig_latency", 32'(w), 32'd1);
    do_shot(1, 280, -1, 1'b0, exp_t'{12'd70, 12'd150, 12'd70, 2'b00}, w);
    do_shot(0, 1200, -1, 1'b0, exp_t'{12'd70, 12'd300, 12'd70, 2'b00}, w);
    do_shot(1, 400, -1, 1'b0, exp_t'{12'd100, 12'd300, 12'd100, 2'b00}, w);
    do_shot(0, 0, -1, 1'b0, exp_t'{12'd100, 12'd4095, 12'd100, 2'b01}, w);
    do_shot(1, 203, -1, 1'b0, exp_t'{12'd50, 12'd4095, 12'd50, 2'b01}, w);
    do_shot(0, 41, -1, 1'b0, exp_t'{12'd10, 12'd10, 12'd50, 2'b00}, w);
    do_shot(1, 20000, -1, 1'b1, exp_t'{12'd10, 12'd10, 12'd4095, 2'b10}, w);
    do_shot(0, 100, 10, 1'b0, exp_t'{12'd25, 12'd25, 12'd4095, 2'b10}, w);

    acc_trig = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (trig != 2'b00) acc_trig++;
    end
    check("drop_idle_trig", 32'(acc_trig), 32'd0);
    check("drop_sel", 32'(sel), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    meas_en = 1'b1;
    w = 0;
    while (trig == 2'b00 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("reenable_trig", 32'(trig), 32'd2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_trig",   32'(trig), 32'd0);
    check("async_rst_front",  32'(dst_front), 32'd4095);
    check("async_rst_rear",   32'(dst_rear), 32'd4095);
    check("async_rst_binary", 32'(binary_dst), 32'd4095);
    check("async_rst_to",     32'(timeout), 32'd0);
    check("async_rst_sel",    32'(sel), 32'd0);
    check("async_rst_valid",  32'(dst_valid), 32'd0);
    @(negedge clk);
    meas_en = 1'b0;
    rst = 1'b0;
    acc_trig = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trig != 2'b00) acc_trig++;
    end
    check("post_rst_trig", 32'(acc_trig), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
